// File: rtl/rate_detector_pkg.sv
// Shared definitions for the strobe-rate detector: parameter defaults,
// FSM state encoding and the classifier result record.
package rate_detector_pkg;

  localparam int unsigned NB_SW_DEF      = 3;
  localparam int unsigned NB_COUNTER_DEF = 8;
  localparam int unsigned R0_DEF         = 15;
  localparam int unsigned R1_DEF         = 7;
  localparam int unsigned R2_DEF         = 3;
  localparam int unsigned R3_DEF         = 1;
  localparam int unsigned TOL_DEF        = 0;
  localparam int unsigned LOCK_CNT_DEF   = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // Result of classifying one strobe interval against R0..R3.
  typedef struct packed {
    logic       hit;
    logic [1:0] code;
  } class_t;

endpackage

// File: rtl/rate_detector_period_meter.sv
// Saturating strobe-interval meter.
// Ports:
//   clock    in   system clock
//   i_reset  in   asynchronous active-low reset
//   i_valid  in   strobe under test
//   meter    out  cycles since the last strobe (1 on the cycle after a strobe),
//                 saturating at all-ones; its value on a strobe cycle is the interval
module rate_detector_period_meter
  import rate_detector_pkg::*;
#(
  parameter int unsigned NB_METER = NB_COUNTER_DEF + 1
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_valid,
  output logic [NB_METER-1:0] meter
);

  // Restart on every strobe, otherwise count up and hold at the top.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      meter <= '0;
    end else if (i_valid) begin
      meter <= NB_METER'(1);
    end else if (meter != '1) begin
      meter <= meter + NB_METER'(1);
    end
  end

endmodule

// File: rtl/rate_detector.sv
// Recovers the switch code that produced a strobe train by measuring the
// interval between strobes, classifying it against R0..R3 and locking once
// LOCK_CNT consecutive intervals agree.
// Ports:
//   clock     in   system clock
//   i_reset   in   asynchronous active-low reset
//   i_valid   in   strobe train under test
//   o_sw      out  recovered code {sel[1:0], en}; en=1 only while locked
//   o_locked  out  rate stable, o_sw valid
//   o_change  out  one-cycle pulse whenever o_sw changes
//   o_timeout out  one-cycle pulse when strobes stop
module rate_detector
  import rate_detector_pkg::*;
#(
  parameter int unsigned NB_SW      = NB_SW_DEF,
  parameter int unsigned NB_COUNTER = NB_COUNTER_DEF,
  parameter int unsigned R0         = R0_DEF,
  parameter int unsigned R1         = R1_DEF,
  parameter int unsigned R2         = R2_DEF,
  parameter int unsigned R3         = R3_DEF,
  parameter int unsigned TOL        = TOL_DEF,
  parameter int unsigned LOCK_CNT   = LOCK_CNT_DEF
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic [NB_SW-1:0] o_sw,
  output logic             o_locked,
  output logic             o_change,
  output logic             o_timeout
);

  localparam int unsigned NB_METER    = NB_COUNTER + 1;
  localparam int unsigned NB_MATCH    = $clog2(LOCK_CNT + 1);
  localparam int unsigned TIMEOUT_LIM = R0 + 1 + TOL;

  logic [NB_METER-1:0] meter;

  state_t              state, state_n;
  logic [1:0]          last_k, last_k_n;
  logic [NB_MATCH-1:0] match_cnt, match_n;
  logic [NB_SW-1:0]    sw_n;
  logic                locked_n, change_n, timeout_n;
  class_t              cls;

  rate_detector_period_meter #(
    .NB_METER (NB_METER)
  ) u_meter (
    .clock   (clock),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .meter   (meter)
  );

  // Interval -> code; scanning high to low lets the lowest k win on overlap.
  function automatic class_t classify(input logic [NB_METER-1:0] n);
    class_t      res;
    int unsigned nv;
    int unsigned tgt;
    res = '0;
    nv  = 32'(n);
    for (int k = 3; k >= 0; k--) begin
      case (k)
        0:       tgt = R0 + 1;
        1:       tgt = R1 + 1;
        2:       tgt = R2 + 1;
        default: tgt = R3 + 1;
      endcase
      if ((nv + TOL >= tgt) && (nv <= tgt + TOL)) begin
        res.hit  = 1'b1;
        res.code = 2'(k);
      end
    end
    return res;
  endfunction

  // State and registered outputs.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      last_k    <= '0;
      match_cnt <= '0;
      o_sw      <= '0;
      o_locked  <= 1'b0;
      o_change  <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state     <= state_n;
      last_k    <= last_k_n;
      match_cnt <= match_n;
      o_sw      <= sw_n;
      o_locked  <= locked_n;
      o_change  <= change_n;
      o_timeout <= timeout_n;
    end
  end

  // Next state and next outputs. A strobe always takes priority over timeout.
  always_comb begin
    state_n   = state;
    last_k_n  = last_k;
    match_n   = match_cnt;
    timeout_n = 1'b0;
    cls       = classify(meter);

    case (state)
      IDLE: begin
        // First strobe only starts the meter; no interval to classify yet.
        if (i_valid) begin
          state_n = MEASURE;
          match_n = '0;
        end
      end
      MEASURE, LOCKED: begin
        if (i_valid) begin
          if (!cls.hit) begin
            state_n = MEASURE;
            match_n = '0;
          end else if (cls.code == last_k) begin
            if (state == MEASURE) begin
              match_n = match_cnt + NB_MATCH'(1);
              if (32'(match_n) >= LOCK_CNT) begin
                state_n = LOCKED;
              end
            end
          end else begin
            last_k_n = cls.code;
            match_n  = NB_MATCH'(1);
            state_n  = (LOCK_CNT <= 1) ? LOCKED : MEASURE;
          end
        end else if (32'(meter) > TIMEOUT_LIM) begin
          state_n   = IDLE;
          match_n   = '0;
          timeout_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        match_n = '0;
      end
    endcase

    locked_n = (state_n == LOCKED);
    sw_n     = locked_n ? NB_SW'({last_k_n, 1'b1}) : '0;
    change_n = (sw_n != o_sw);
  end

endmodule

// File: tb/tb_rate_detector.sv
// Self-checking bench for rate_detector: two instances (TOL=0 and TOL=1)
// observe the same strobe train; expected outputs come from hand-derived tables.
module tb_rate_detector;

  logic       clock;
  logic       i_reset;
  logic       i_valid;
  logic [2:0] sw0, sw1;
  logic       lk0, lk1, ch0, ch1, to0, to1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int gap;
    int sw0; int lk0; int ch0;
    int sw1; int lk1; int ch1;
  } vec_t;

  vec_t stim_q[$];
  vec_t sb_q[$];

  rate_detector #(.TOL(0)) dut0 (
    .clock(clock), .i_reset(i_reset), .i_valid(i_valid),
    .o_sw(sw0), .o_locked(lk0), .o_change(ch0), .o_timeout(to0)
  );

  rate_detector #(.TOL(1)) dut1 (
    .clock(clock), .i_reset(i_reset), .i_valid(i_valid),
    .o_sw(sw1), .o_locked(lk1), .o_change(ch1), .o_timeout(to1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int g, input int s0, input int l0, input int c0,
                     input int s1, input int l1, input int c1);
    vec_t v;
    v.gap = g; v.sw0 = s0; v.lk0 = l0; v.ch0 = c0;
    v.sw1 = s1; v.lk1 = l1; v.ch1 = c1;
    stim_q.push_back(v);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " sw0"}, int'(sw0), 0);
    check({tag, " lk0"}, int'(lk0), 0);
    check({tag, " ch0"}, int'(ch0), 0);
    check({tag, " to0"}, int'(to0), 0);
    check({tag, " sw1"}, int'(sw1), 0);
    check({tag, " lk1"}, int'(lk1), 0);
    check({tag, " ch1"}, int'(ch1), 0);
    check({tag, " to1"}, int'(to1), 0);
  endtask

  // Strobe 'gap' cycles after the previous one; no timeout may appear meanwhile.
  task automatic strobe(input int gap, input string tag);
    for (int c = 1; c < gap; c++) begin
      i_valid = 1'b0;
      @(posedge clock); #1;
      check({tag, " gap to0"}, int'(to0), 0);
      check({tag, " gap to1"}, int'(to1), 0);
    end
    i_valid = 1'b1;
    @(posedge clock); #1;
    i_valid = 1'b0;
  endtask

  // Apply every queued vector; expectations go through the scoreboard queue.
  task automatic run_vectors(input string phase);
    int   idx;
    vec_t v, e;
    string tag;
    idx = 0;
    while (stim_q.size() > 0) begin
      v = stim_q.pop_front();
      sb_q.push_back(v);
      tag = $sformatf("%s[%0d]", phase, idx);
      strobe(v.gap, tag);
      e = sb_q.pop_front();
      check({tag, " sw0"}, int'(sw0), e.sw0);
      check({tag, " lk0"}, int'(lk0), e.lk0);
      check({tag, " ch0"}, int'(ch0), e.ch0);
      check({tag, " to0"}, int'(to0), 0);
      check({tag, " sw1"}, int'(sw1), e.sw1);
      check({tag, " lk1"}, int'(lk1), e.lk1);
      check({tag, " ch1"}, int'(ch1), e.ch1);
      check({tag, " to1"}, int'(to1), 0);
      idx++;
    end
  endtask

  // Async reset between edges; release with a strobe on the very first edge.
  task automatic reset_mid(input string tag);
    #2 i_reset = 1'b0;
    #1;
    check_all_zero({tag, " async"});
    @(posedge clock); #1;
    i_reset = 1'b1;
    i_valid = 1'b1;
    @(posedge clock); #1;
    i_valid = 1'b0;
    check_all_zero({tag, " release"});
  endtask

  initial begin
    i_reset = 1'b0;
    i_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("reset");
    i_reset = 1'b1;

    // R0 lock, switch to R1, R3, then an overlap interval (3) that TOL=1 maps to R2.
    add( 3, 0,0,0, 0,0,0);
    add(16, 0,0,0, 0,0,0);
    add(16, 0,0,0, 0,0,0);
    add(16, 1,1,1, 1,1,1);
    add(16, 1,1,0, 1,1,0);
    add( 8, 0,0,1, 0,0,1);
    add( 8, 0,0,0, 0,0,0);
    add( 8, 3,1,1, 3,1,1);
    add( 2, 0,0,1, 0,0,1);
    add( 2, 0,0,0, 0,0,0);
    add( 2, 7,1,1, 7,1,1);
    add( 3, 0,0,1, 0,0,1);
    add( 4, 0,0,0, 0,0,0);
    add( 4, 0,0,0, 5,1,1);
    add( 4, 5,1,1, 5,1,0);
    run_vectors("lock");

    // Strobes stop while locked: timeout 17 cycles after the strobe (18 with TOL=1).
    for (int n = 1; n <= 30; n++) begin
      @(posedge clock); #1;
      check($sformatf("timeout to0 n=%0d", n), int'(to0), (n == 17) ? 1 : 0);
      check($sformatf("timeout to1 n=%0d", n), int'(to1), (n == 18) ? 1 : 0);
      check($sformatf("timeout ch0 n=%0d", n), int'(ch0), (n == 17) ? 1 : 0);
      check($sformatf("timeout ch1 n=%0d", n), int'(ch1), (n == 18) ? 1 : 0);
    end
    check_all_zero("after timeout");

    // Strobe landing exactly on the timeout threshold is classified, then R3 sweep.
    add( 3, 0,0,0, 0,0,0);
    add(17, 0,0,0, 0,0,0);
    add( 2, 0,0,0, 0,0,0);
    add( 2, 0,0,0, 0,0,0);
    add( 2, 7,1,1, 7,1,1);
    run_vectors("edge");

    // Reset while locked; relock needs the full three intervals.
    @(posedge clock); #1;
    reset_mid("rst1");
    add(16, 0,0,0, 0,0,0);
    add(16, 0,0,0, 0,0,0);
    add(16, 1,1,1, 1,1,1);
    run_vectors("relock");

    // Intervals 8,8,9,8: TOL=0 restarts on 9, TOL=1 locks on the 3rd interval.
    @(posedge clock); #1;
    reset_mid("rst2");
    add( 8, 0,0,0, 0,0,0);
    add( 8, 0,0,0, 0,0,0);
    add( 9, 0,0,0, 3,1,1);
    add( 8, 0,0,0, 3,1,0);
    add( 8, 0,0,0, 3,1,0);
    add( 8, 3,1,1, 3,1,0);
    add( 8, 3,1,0, 3,1,0);
    run_vectors("tol");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
